// File: rtl/mac_row_processor.sv
// Row-by-columns multiply-accumulate engine: one A row against COLS B columns,
// one product term per cycle, with optional accumulation across jobs and output clamping.
module mac_row_processor #(
    parameter int unsigned SIZE       = 4,
    parameter int unsigned CELL_WIDTH = 8,
    parameter int unsigned COLS       = 4,
    parameter int unsigned ACC_WIDTH  = 2*CELL_WIDTH+4
) (
    input  logic                              in_clk,
    input  logic                              in_reset,
    input  logic                              in_ready,
    input  logic [SIZE*CELL_WIDTH-1:0]        in_row_a,
    input  logic [COLS*SIZE*CELL_WIDTH-1:0]   in_cols_b,
    input  logic                              in_accumulate,
    input  logic                              in_saturate,
    input  logic                              out_ack,
    output logic                              out_busy,
    output logic                              out_ready,
    output logic [COLS*CELL_WIDTH-1:0]        out_cells_c,
    output logic                              out_overflow
);

    localparam int unsigned KW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned PW = 2*CELL_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_FMT, S_DONE} state_t;

    state_t state_q, state_d;

    logic [SIZE-1:0][CELL_WIDTH-1:0]            a_q, a_d;
    logic [COLS-1:0][SIZE-1:0][CELL_WIDTH-1:0]  b_q, b_d;
    logic                                       sat_q, sat_d;
    logic [KW-1:0]                              k_q, k_d;
    logic [COLS-1:0][ACC_WIDTH-1:0]             acc_q, acc_d;
    logic [COLS-1:0][CELL_WIDTH-1:0]            cells_q, cells_d;
    logic                                       ovf_q, ovf_d;
    logic                                       ready_q, ready_d;
    logic                                       busy_q, busy_d;
    logic [PW-1:0]                              prod;

    logic k_last;
    assign k_last = (k_q == KW'(SIZE-1));

    // State register
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_ready) state_d = S_MAC;
            S_MAC:   if (k_last)   state_d = S_FMT;
            S_FMT:                 state_d = S_DONE;
            S_DONE:  if (out_ack)  state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sat_d   = sat_q;
        k_d     = k_q;
        acc_d   = acc_q;
        cells_d = cells_q;
        ovf_d   = ovf_q;
        ready_d = ready_q;
        busy_d  = (state_d != S_IDLE);
        prod    = '0;
        case (state_q)
            S_IDLE: begin
                if (in_ready) begin
                    a_d   = in_row_a;
                    b_d   = in_cols_b;
                    sat_d = in_saturate;
                    k_d   = '0;
                    if (!in_accumulate) acc_d = '0;
                end
            end
            S_MAC: begin
                for (int j = 0; j < COLS; j++) begin
                    prod     = PW'(a_q[k_q]) * PW'(b_q[j][k_q]);
                    acc_d[j] = acc_q[j] + ACC_WIDTH'(prod);
                end
                k_d = k_last ? '0 : k_q + KW'(1);
            end
            S_FMT: begin
                ready_d = 1'b1;
                ovf_d   = 1'b0;
                for (int j = 0; j < COLS; j++) begin
                    // Any bit above the cell width means the value does not fit
                    if (|acc_q[j][ACC_WIDTH-1:CELL_WIDTH]) begin
                        ovf_d      = 1'b1;
                        cells_d[j] = sat_q ? '1 : acc_q[j][CELL_WIDTH-1:0];
                    end else begin
                        cells_d[j] = acc_q[j][CELL_WIDTH-1:0];
                    end
                end
            end
            S_DONE: begin
                if (out_ack) ready_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
            k_q     <= '0;
            acc_q   <= '0;
            cells_q <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sat_q   <= sat_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            cells_q <= cells_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign out_busy     = busy_q;
    assign out_ready    = ready_q;
    assign out_cells_c  = cells_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_mac_row_processor.sv
// Table-driven, scoreboard-checked bench for mac_row_processor at default parameters
// (SIZE=4, CELL_WIDTH=8, COLS=4).
module tb_mac_row_processor;

    localparam int SIZE = 4;
    localparam int CW   = 8;
    localparam int COLS = 4;

    logic                        in_clk = 1'b0;
    logic                        in_reset;
    logic                        in_ready;
    logic [SIZE*CW-1:0]          in_row_a;
    logic [COLS*SIZE*CW-1:0]     in_cols_b;
    logic                        in_accumulate;
    logic                        in_saturate;
    logic                        out_ack;
    logic                        out_busy;
    logic                        out_ready;
    logic [COLS*CW-1:0]          out_cells_c;
    logic                        out_overflow;

    mac_row_processor dut (
        .in_clk        (in_clk),
        .in_reset      (in_reset),
        .in_ready      (in_ready),
        .in_row_a      (in_row_a),
        .in_cols_b     (in_cols_b),
        .in_accumulate (in_accumulate),
        .in_saturate   (in_saturate),
        .out_ack       (out_ack),
        .out_busy      (out_busy),
        .out_ready     (out_ready),
        .out_cells_c   (out_cells_c),
        .out_overflow  (out_overflow)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [31:0]  a;
        logic [127:0] b;
        logic         acc;
        logic         sat;
        logic [31:0]  cells;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [31:0] cells;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] row(input int c0, input int c1, input int c2, input int c3);
        return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready(input int start, output int lat);
        lat = start;
        while (!out_ready && lat < 20) begin
            @(posedge in_clk); #1;
            lat++;
        end
    endtask

    task automatic check_out();
        exp_t e;
        chk("ready_high", out_ready, 1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sb.pop_front();
        last_exp = e;
        chk("cells", out_cells_c, e.cells);
        chk("overflow", out_overflow, e.ovf);
    endtask

    task automatic finish_ack();
        out_ack = 1'b1;
        @(posedge in_clk); #1;
        out_ack = 1'b0;
        chk("ready_after_ack", out_ready, 0);
        chk("busy_after_ack", out_busy, 0);
        chk("cells_kept_idle", out_cells_c, last_exp.cells);
        chk("ovf_kept_idle", out_overflow, last_exp.ovf);
    endtask

    task automatic drive(input vec_t v);
        in_row_a      = v.a;
        in_cols_b     = v.b;
        in_accumulate = v.acc;
        in_saturate   = v.sat;
    endtask

    task automatic run_job(input vec_t v, input bit disturb, input int hold);
        int lat;
        @(negedge in_clk);
        drive(v);
        in_ready = 1'b1;
        sb.push_back('{v.cells, v.ovf});
        @(posedge in_clk); #1;
        in_ready = 1'b0;
        chk("busy_after_start", out_busy, 1);
        lat = 0;
        if (disturb) begin
            // Stray request, ack and operand changes while in MAC must be ignored
            in_ready      = 1'b1;
            out_ack       = 1'b1;
            in_row_a      = $urandom;
            in_cols_b     = {$urandom, $urandom, $urandom, $urandom};
            in_accumulate = ~v.acc;
            in_saturate   = ~v.sat;
            @(posedge in_clk); #1;
            lat      = 1;
            in_ready = 1'b0;
            out_ack  = 1'b0;
        end
        wait_ready(lat, lat);
        chk("latency", lat, SIZE+1);
        check_out();
        for (int c = 0; c < hold; c++) begin
            @(posedge in_clk); #1;
            chk("hold_ready", out_ready, 1);
            chk("hold_cells", out_cells_c, last_exp.cells);
        end
        finish_ack();
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v;
        int   lat;

        tbl[0] = '{row(1,2,3,4), {row(0,0,0,1), row(0,0,1,0), row(0,1,0,0), row(1,0,0,0)},
                   1'b0, 1'b1, row(1,2,3,4), 1'b0};
        tbl[1] = '{row(255,255,255,255), {4{row(255,255,255,255)}}, 1'b0, 1'b1,
                   row(255,255,255,255), 1'b1};
        tbl[2] = '{row(255,255,255,255), {4{row(255,255,255,255)}}, 1'b0, 1'b0,
                   row(4,4,4,4), 1'b1};
        tbl[3] = '{row(1,1,1,1), {4{row(1,1,1,1)}}, 1'b0, 1'b1, row(4,4,4,4), 1'b0};
        tbl[4] = '{row(1,1,1,1), {4{row(1,1,1,1)}}, 1'b1, 1'b1, row(8,8,8,8), 1'b0};
        tbl[5] = '{row(1,1,1,1), {4{row(1,1,1,1)}}, 1'b0, 1'b1, row(4,4,4,4), 1'b0};
        tbl[6] = '{row(10,20,30,40), {row(4,4,4,4), row(3,3,3,3), row(2,2,2,2), row(1,1,1,1)},
                   1'b0, 1'b1, row(100,200,255,255), 1'b1};
        tbl[7] = '{row(10,20,30,40), {row(4,4,4,4), row(3,3,3,3), row(2,2,2,2), row(1,1,1,1)},
                   1'b0, 1'b0, row(100,200,44,144), 1'b1};
        tbl[8] = '{row(10,20,30,40), {row(4,4,4,4), row(3,3,3,3), row(2,2,2,2), row(1,1,1,1)},
                   1'b1, 1'b0, row(200,144,88,32), 1'b1};

        in_reset = 1'b0; in_ready = 1'b0; out_ack = 1'b0;
        in_row_a = '0; in_cols_b = '0; in_accumulate = 1'b0; in_saturate = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        chk("rst_busy", out_busy, 0);
        chk("rst_ready", out_ready, 0);
        chk("rst_cells", out_cells_c, 0);
        chk("rst_ovf", out_overflow, 0);
        @(negedge in_clk);
        in_reset = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        chk("idle_no_request", out_busy, 0);

        // Table of jobs; accumulators carry between consecutive entries
        for (int i = 0; i < 9; i++)
            run_job(tbl[i], (i == 5), (i == 3) ? 10 : 0);

        // Back-to-back jobs with in_ready held high
        @(negedge in_clk);
        drive(tbl[3]);
        in_ready = 1'b1;
        sb.push_back('{tbl[3].cells, tbl[3].ovf});
        @(posedge in_clk); #1;
        wait_ready(0, lat);
        chk("b2b_latency1", lat, SIZE+1);
        check_out();
        drive(tbl[4]);
        sb.push_back('{tbl[4].cells, tbl[4].ovf});
        out_ack = 1'b1;
        @(posedge in_clk); #1;
        out_ack = 1'b0;
        chk("b2b_gap_busy", out_busy, 0);
        chk("b2b_gap_ready", out_ready, 0);
        @(posedge in_clk); #1;
        in_ready = 1'b0;
        chk("b2b_restart_busy", out_busy, 1);
        wait_ready(0, lat);
        chk("b2b_latency2", lat, SIZE+1);
        check_out();
        finish_ack();

        // Reset during MAC at k=2, then accumulate must start from zero
        @(negedge in_clk);
        drive(tbl[4]);
        in_ready = 1'b1;
        @(posedge in_clk); #1;
        in_ready = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        in_reset = 1'b0;
        #1;
        chk("midrst_busy", out_busy, 0);
        chk("midrst_ready", out_ready, 0);
        chk("midrst_cells", out_cells_c, 0);
        chk("midrst_ovf", out_overflow, 0);
        @(negedge in_clk);
        in_reset = 1'b1;
        v = '{row(1,0,0,0), {row(0,0,0,0), row(0,0,0,0), row(0,0,0,0), row(5,5,5,5)},
              1'b1, 1'b1, row(5,0,0,0), 1'b0};
        run_job(v, 1'b0, 0);

        if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
